mult_err_sweep_ctrl: RTL and testbench
======================================

Name: mult_err_sweep_ctrl

Overview:
- Hardware sweep controller for multiplier error characterisation.
- Drives every operand pair (a, b) into an exact multiplier and an approximate multiplier (e.g. hlr_bm2) in parallel, one pair per clock.
- Accumulates the absolute error sum, the maximum exact product and the pair count, so software computes NMED = err_sum / (count × max_exact).
- Sits beside the multiplier pair in the characterisation top level; both multipliers are external and combinational.

Parameters:
- OP_W, 8, operand width; signed two's complement.
- ACC_W, 40, error accumulator width; must be ≥ 4*OP_W+1.
- PROD_W, 2*OP_W, localparam, product width.
- CNT_W, 2*OP_W+1, localparam, pair-count width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  single-cycle pulse; starts a sweep.
- i_abort  in  1  stops the sweep in progress.
- o_a  out  OP_W  operand A to both multipliers.
- o_b  out  OP_W  operand B to both multipliers.
- i_prod_exact  in  PROD_W  signed exact product of o_a*o_b.
- i_prod_approx  in  PROD_W  signed approximate product of o_a*o_b.
- o_busy  out  1  high during RUN and DRAIN.
- o_done  out  1  high in DONE; results valid.
- o_err_sum  out  ACC_W  sum of |approx − exact|, unsigned.
- o_max_exact  out  PROD_W  largest signed exact product seen; initial value 0.
- o_count  out  CNT_W  number of pairs accumulated.

Behaviour:
- Reset (async, any state): state=IDLE; o_a, o_b, o_err_sum, o_max_exact, o_count = 0; o_busy=0, o_done=0; pipeline valids cleared.
- States:
  - IDLE: i_start → RUN; clears accumulators and operand counters.
  - RUN: each cycle presents one pair. Sweep order: o_a outer, o_b inner. Raw counter values run 0..2^OP_W−1 and wrap through negative values, so 0,1,…,127,−128,…,−1. After the last pair (a=b=all-ones) → DRAIN.
  - DRAIN: 2 cycles to empty the pipeline → DONE.
  - DONE: o_done=1, outputs held. i_start → RUN (accumulators cleared, o_done drops next cycle).
- Pipeline:
  - Stage 1: on each RUN cycle, register both products with a valid bit.
  - Stage 2: diff = approx − exact, computed at PROD_W+1 bits. Add |diff| (zero-extended) to err_sum. If exact > max_exact (signed compare), update max_exact. Increment count.
- Latency: the edge sampling i_start is edge 0. First pair is on o_a/o_b after edge 1. o_done rises after edge 2^(2*OP_W)+3 (65539 for OP_W=8).
- Handshake/boundaries:
  - i_start in RUN or DRAIN: ignored.
  - i_start and i_abort together in IDLE or DONE: abort wins, and the state becomes or stays IDLE.
  - i_abort in RUN or DRAIN: → IDLE next edge; o_busy=0, o_done=0, pipeline valids flushed, partial results held until next start.
  - Accumulator never wraps at default widths; no saturation logic.
- Operands change only on RUN cycles; o_a/o_b are held in DRAIN and DONE.

Optional Feature:
- Macro: MULT_ERR_MAX_ABS_EN.
- Defined:
  - Adds output o_max_abs_err (PROD_W+1 bits, unsigned), reset/cleared to 0.
  - Updated in stage 2 whenever |diff| is strictly greater than the current value.
  - Adds output o_max_abs_a/o_max_abs_b (OP_W each), the operands of the first pair reaching that maximum.
  - Operands travel with the pipeline.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package mult_err_pkg:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - default OP_W/ACC_W constants
  - function abs_diff(exact, approx) returning the (PROD_W+1)-bit magnitude.
- One sub-module: mult_err_accum. It holds pipeline stage 2: err_sum, max_exact, count and the optional max-abs tracking, with a clear input and a valid input. The FSM and operand counters stay in the top.

Test Plan:
- Both product inputs tied to an exact model → o_err_sum=0, o_max_exact=16384 (−128×−128), o_count=65536. o_done rises exactly 65539 edges after start.
- Approx stub = exact+1 → o_err_sum=65536. Approx stub = exact−3 → o_err_sum=196608 (abs applied).
- Approx stub = exact+5 only when a=−1, b=−1 (last pair) → o_err_sum=5, proving DRAIN captures the final pair. With MULT_ERR_MAX_ABS_EN: o_max_abs_err=5, o_max_abs_a=o_max_abs_b=0xFF.
- i_abort at RUN cycle 100 → o_busy=0 next edge, o_done stays 0, o_count ≤ 100. Re-start → full results as in scenario 1.
- i_rst asserted mid-DRAIN, asynchronously between edges → all outputs 0 immediately. i_start during RUN ignored (o_count still 65536). i_start in DONE reruns with cleared accumulators.
- OP_W=4 instance against a software NMED model of a truncating approx stub → o_err_sum, o_max_exact (=64), o_count (=256) match the model.

Source files
------------

// File: rtl/mult_err_pkg.sv
// Shared types, default widths and the error-magnitude helper for the multiplier sweep.
package mult_err_pkg;

    localparam int unsigned DefOpW  = 8;
    localparam int unsigned DefAccW = 40;

    // abs_diff works on products up to AbsW-1 bits; narrower products are sign-extended in.
    localparam int unsigned AbsW = 33;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    function automatic logic [AbsW-1:0] abs_diff(input logic signed [AbsW-2:0] exact,
                                                 input logic signed [AbsW-2:0] approx);
        logic signed [AbsW-1:0] diff;
        diff = AbsW'(approx) - AbsW'(exact);
        return diff[AbsW-1] ? $unsigned(-diff) : $unsigned(diff);
    endfunction

endpackage

// File: rtl/mult_err_sweep_ctrl_if.sv
// Sweep controller <-> multiplier pair / software interface.
// MULT_ERR_MAX_ABS_EN adds the max-|error| result signals.
interface mult_err_sweep_ctrl_if
    import mult_err_pkg::*;
#(
    parameter int unsigned OP_W  = DefOpW,
    parameter int unsigned ACC_W = DefAccW
);
    localparam int unsigned PROD_W = 2 * OP_W;
    localparam int unsigned CNT_W  = 2 * OP_W + 1;

    logic              i_start;
    logic              i_abort;
    logic [OP_W-1:0]   o_a;
    logic [OP_W-1:0]   o_b;
    logic [PROD_W-1:0] i_prod_exact;
    logic [PROD_W-1:0] i_prod_approx;
    logic              o_busy;
    logic              o_done;
    logic [ACC_W-1:0]  o_err_sum;
    logic [PROD_W-1:0] o_max_exact;
    logic [CNT_W-1:0]  o_count;
`ifdef MULT_ERR_MAX_ABS_EN
    logic [PROD_W:0]   o_max_abs_err;
    logic [OP_W-1:0]   o_max_abs_a;
    logic [OP_W-1:0]   o_max_abs_b;
`endif

    modport master (
`ifdef MULT_ERR_MAX_ABS_EN
        output o_max_abs_err, o_max_abs_a, o_max_abs_b,
`endif
        input  i_start, i_abort, i_prod_exact, i_prod_approx,
        output o_a, o_b, o_busy, o_done, o_err_sum, o_max_exact, o_count
    );

    modport slave (
`ifdef MULT_ERR_MAX_ABS_EN
        input  o_max_abs_err, o_max_abs_a, o_max_abs_b,
`endif
        output i_start, i_abort, i_prod_exact, i_prod_approx,
        input  o_a, o_b, o_busy, o_done, o_err_sum, o_max_exact, o_count
    );

endinterface

// File: rtl/mult_err_accum.sv
// Pipeline stage 2: accumulates |approx - exact|, the largest exact product and the pair count.
// With MULT_ERR_MAX_ABS_EN it also tracks the largest |error| and the first operands hitting it.
module mult_err_accum
    import mult_err_pkg::*;
#(
    parameter int unsigned OP_W  = DefOpW,
    parameter int unsigned ACC_W = DefAccW
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clr,
    input  logic                     i_vld,
    input  logic signed [2*OP_W-1:0] i_exact,
    input  logic signed [2*OP_W-1:0] i_approx,
`ifdef MULT_ERR_MAX_ABS_EN
    input  logic [OP_W-1:0]          i_a,
    input  logic [OP_W-1:0]          i_b,
    output logic [2*OP_W:0]          o_max_abs_err,
    output logic [OP_W-1:0]          o_max_abs_a,
    output logic [OP_W-1:0]          o_max_abs_b,
`endif
    output logic [ACC_W-1:0]         o_err_sum,
    output logic [2*OP_W-1:0]        o_max_exact,
    output logic [2*OP_W:0]          o_count
);
    localparam int unsigned PROD_W = 2 * OP_W;
    localparam int unsigned CNT_W  = 2 * OP_W + 1;

    logic [AbsW-1:0]          abs_w;
    logic [PROD_W:0]          abs_cur;
    logic [ACC_W-1:0]         err_sum_q;
    logic signed [PROD_W-1:0] max_exact_q;
    logic [CNT_W-1:0]         count_q;

    assign abs_w   = abs_diff((AbsW-1)'(i_exact), (AbsW-1)'(i_approx));
    assign abs_cur = (PROD_W+1)'(abs_w);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_sum_q   <= '0;
            max_exact_q <= '0;
            count_q     <= '0;
        end else if (i_clr) begin
            err_sum_q   <= '0;
            max_exact_q <= '0;
            count_q     <= '0;
        end else if (i_vld) begin
            err_sum_q <= err_sum_q + ACC_W'(abs_cur);
            if (i_exact > max_exact_q) begin
                max_exact_q <= i_exact;
            end
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign o_err_sum   = err_sum_q;
    assign o_max_exact = max_exact_q;
    assign o_count     = count_q;

`ifdef MULT_ERR_MAX_ABS_EN
    logic [PROD_W:0] max_abs_q;
    logic [OP_W-1:0] max_abs_a_q;
    logic [OP_W-1:0] max_abs_b_q;

    // Strict compare keeps the operands of the first pair reaching the maximum.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            max_abs_q   <= '0;
            max_abs_a_q <= '0;
            max_abs_b_q <= '0;
        end else if (i_clr) begin
            max_abs_q   <= '0;
            max_abs_a_q <= '0;
            max_abs_b_q <= '0;
        end else if (i_vld && (abs_cur > max_abs_q)) begin
            max_abs_q   <= abs_cur;
            max_abs_a_q <= i_a;
            max_abs_b_q <= i_b;
        end
    end

    assign o_max_abs_err = max_abs_q;
    assign o_max_abs_a   = max_abs_a_q;
    assign o_max_abs_b   = max_abs_b_q;
`endif

endmodule

// File: rtl/mult_err_sweep_ctrl.sv
// Sweeps every signed operand pair through an external exact/approximate multiplier pair.
// MULT_ERR_MAX_ABS_EN carries operands down the pipeline for max-|error| tracking.
module mult_err_sweep_ctrl
    import mult_err_pkg::*;
#(
    parameter int unsigned OP_W  = DefOpW,
    parameter int unsigned ACC_W = DefAccW
) (
    input logic                   i_clk,
    input logic                   i_rst,
    mult_err_sweep_ctrl_if.master bus
);
    localparam int unsigned PROD_W = 2 * OP_W;

    state_e            state_q, state_d;
    logic [OP_W-1:0]   a_q, b_q;
    logic              pair_vld_q;
    logic              drain_q;
    logic              s1_vld_q;
    logic [PROD_W-1:0] s1_exact_q, s1_approx_q;
    logic              start_ok, run_adv, last_pair;

    // pair_vld_q marks that a_q/b_q hold a pair to be sampled; the first RUN cycle only primes it.
    assign last_pair = pair_vld_q && (a_q == '1) && (b_q == '1);
    assign run_adv   = (state_q == StRun) && (state_d == StRun);

    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (bus.i_abort) begin
                    state_d = StIdle;
                end else if (bus.i_start) begin
                    state_d  = StRun;
                    start_ok = 1'b1;
                end
            end
            StRun: begin
                if (bus.i_abort) state_d = StIdle;
                else if (last_pair) state_d = StDrain;
            end
            StDrain: begin
                if (bus.i_abort) state_d = StIdle;
                else if (drain_q) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= (state_q == StDrain) && (state_d == StDrain);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_q         <= '0;
            b_q         <= '0;
            pair_vld_q  <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_exact_q  <= '0;
            s1_approx_q <= '0;
        end else begin
            if (start_ok) begin
                a_q <= '0;
                b_q <= '0;
            end else if (run_adv && pair_vld_q) begin
                {a_q, b_q} <= {a_q, b_q} + PROD_W'(1);
            end
            pair_vld_q  <= run_adv;
            s1_vld_q    <= (state_q == StRun) && pair_vld_q && !bus.i_abort;
            s1_exact_q  <= bus.i_prod_exact;
            s1_approx_q <= bus.i_prod_approx;
        end
    end

`ifdef MULT_ERR_MAX_ABS_EN
    logic [OP_W-1:0] s1_a_q, s1_b_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_a_q <= '0;
            s1_b_q <= '0;
        end else begin
            s1_a_q <= a_q;
            s1_b_q <= b_q;
        end
    end
`endif

    mult_err_accum #(
        .OP_W  (OP_W),
        .ACC_W (ACC_W)
    ) u_accum (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_clr         (start_ok),
        .i_vld         (s1_vld_q && !bus.i_abort),
        .i_exact       (s1_exact_q),
        .i_approx      (s1_approx_q),
`ifdef MULT_ERR_MAX_ABS_EN
        .i_a           (s1_a_q),
        .i_b           (s1_b_q),
        .o_max_abs_err (bus.o_max_abs_err),
        .o_max_abs_a   (bus.o_max_abs_a),
        .o_max_abs_b   (bus.o_max_abs_b),
`endif
        .o_err_sum     (bus.o_err_sum),
        .o_max_exact   (bus.o_max_exact),
        .o_count       (bus.o_count)
    );

    assign bus.o_a    = a_q;
    assign bus.o_b    = b_q;
    assign bus.o_busy = (state_q == StRun) || (state_q == StDrain);
    assign bus.o_done = (state_q == StDone);

endmodule

// File: tb/tb_mult_err_sweep_ctrl.sv
// Self-checking bench: OP_W=4 sweep controller against behavioural multiplier stubs and a
// software model of the error statistics, compared through a scoreboard queue.
module tb_mult_err_sweep_ctrl;

    localparam int unsigned OpW     = 4;
    localparam int unsigned AccW    = 40;
    localparam int unsigned PW      = 2 * OpW;
    localparam int          NPairs  = 1 << (2 * OpW);
    localparam int          Latency = NPairs + 3;

    typedef struct {
        longint err;
        longint maxex;
        longint cnt;
        longint maxabs;
        longint maxa;
        longint maxb;
    } exp_t;

    exp_t   exp_q[$];
    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     mode_r = 0;
    int     n_tests = 0;
    int     n_fail = 0;

    mult_err_sweep_ctrl_if #(.OP_W(OpW), .ACC_W(AccW)) bus ();

    mult_err_sweep_ctrl #(
        .OP_W  (OpW),
        .ACC_W (AccW)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic signed [PW-1:0] f_exact(input logic [OpW-1:0] a,
                                                     input logic [OpW-1:0] b);
        logic signed [PW-1:0] sa, sb;
        sa = PW'($signed(a));
        sb = PW'($signed(b));
        return sa * sb;
    endfunction

    // 1: +1, 2: -3, 3: +5 on the last pair only, 4: truncate two LSBs, else exact.
    function automatic logic signed [PW-1:0] f_approx(input int mode, input logic [OpW-1:0] a,
                                                      input logic [OpW-1:0] b);
        logic signed [PW-1:0] ex;
        ex = f_exact(a, b);
        case (mode)
            1:       return ex + PW'(1);
            2:       return ex - PW'(3);
            3:       return (a == {OpW{1'b1}} && b == {OpW{1'b1}}) ? ex + PW'(5) : ex;
            4:       return ex & ~PW'(3);
            default: return ex;
        endcase
    endfunction

    always_comb begin
        bus.i_prod_exact  = f_exact(bus.o_a, bus.o_b);
        bus.i_prod_approx = f_approx(mode_r, bus.o_a, bus.o_b);
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_expected(input int mode);
        exp_t            e;
        logic [OpW-1:0]  a, b;
        longint          ex, ap, d;
        e = '{default: 0};
        for (int ia = 0; ia < (1 << OpW); ia++) begin
            for (int ib = 0; ib < (1 << OpW); ib++) begin
                a  = OpW'(ia);
                b  = OpW'(ib);
                ex = longint'(f_exact(a, b));
                ap = longint'(f_approx(mode, a, b));
                d  = (ap > ex) ? ap - ex : ex - ap;
                e.err += d;
                if (ex > e.maxex) e.maxex = ex;
                e.cnt++;
                if (d > e.maxabs) begin
                    e.maxabs = d;
                    e.maxa   = ia;
                    e.maxb   = ib;
                end
            end
        end
        exp_q.push_back(e);
    endtask

    // act: 0 plain, 1 start pulse during RUN, 2 abort at RUN cycle 'at', 3 async reset after 'at'.
    task automatic run_sweep(input int mode, input int act, input int at);
        int   n;
        exp_t e;
        mode_r = mode;
        if (act <= 1) push_expected(mode);
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        check_eq("start_busy", longint'(bus.o_busy), 1);
        check_eq("start_done_low", longint'(bus.o_done), 0);
        n = 0;
        while (bus.o_done !== 1'b1 && n < Latency + 20) begin
            if (act == 1) bus.i_start = (n == at);
            if (act == 2) bus.i_abort = (n == at);
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                check_eq("first_a", longint'(bus.o_a), 0);
                check_eq("first_b", longint'(bus.o_b), 0);
            end
            if (n == 2) check_eq("second_b", longint'(bus.o_b), 1);
            if (act == 2 && n == at + 1) begin
                bus.i_abort = 1'b0;
                check_eq("abort_busy", longint'(bus.o_busy), 0);
                check_eq("abort_done", longint'(bus.o_done), 0);
                check_eq("abort_count_le", (bus.o_count <= (OpW * 2 + 1)'(at)) ? 1 : 0, 1);
                repeat (5) @(posedge clk);
                #1;
                check_eq("abort_done_stays", longint'(bus.o_done), 0);
                return;
            end
            if (act == 3 && n == at) begin
                check_eq("drain_busy", longint'(bus.o_busy), 1);
                #2 rst = 1'b1;
                #1;
                check_eq("arst_err", longint'(bus.o_err_sum), 0);
                check_eq("arst_max", longint'(bus.o_max_exact), 0);
                check_eq("arst_cnt", longint'(bus.o_count), 0);
                check_eq("arst_busy", longint'(bus.o_busy), 0);
                check_eq("arst_ab", longint'({bus.o_a, bus.o_b}), 0);
                @(posedge clk); #1;
                rst = 1'b0;
                @(posedge clk); #1;
                check_eq("arst_done", longint'(bus.o_done), 0);
                return;
            end
        end
        bus.i_start = 1'b0;
        check_eq("done_latency", n, Latency);
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            check_eq("err_sum", longint'(bus.o_err_sum), e.err);
            check_eq("max_exact", longint'(bus.o_max_exact), e.maxex);
            check_eq("count", longint'(bus.o_count), e.cnt);
`ifdef MULT_ERR_MAX_ABS_EN
            check_eq("max_abs_err", longint'(bus.o_max_abs_err), e.maxabs);
            check_eq("max_abs_a", longint'(bus.o_max_abs_a), e.maxa);
            check_eq("max_abs_b", longint'(bus.o_max_abs_b), e.maxb);
`endif
        end
    endtask

    initial begin
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_err", longint'(bus.o_err_sum), 0);
        check_eq("rst_max", longint'(bus.o_max_exact), 0);
        check_eq("rst_cnt", longint'(bus.o_count), 0);
        check_eq("rst_ab", longint'({bus.o_a, bus.o_b}), 0);
        check_eq("rst_busy", longint'(bus.o_busy), 0);
        check_eq("rst_done", longint'(bus.o_done), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_sweep(0, 0, 0);              // exact: err 0, max 64, count 256
        check_eq("exact_max_const", longint'(bus.o_max_exact), 64);
        check_eq("exact_cnt_const", longint'(bus.o_count), NPairs);
        run_sweep(1, 1, 50);             // +1 with a stray start mid-RUN
        check_eq("plus1_err_const", longint'(bus.o_err_sum), NPairs);
        run_sweep(2, 0, 0);              // -3, abs applied
        check_eq("minus3_err_const", longint'(bus.o_err_sum), 3 * NPairs);
        run_sweep(3, 0, 0);              // only the final pair differs
        check_eq("last_err_const", longint'(bus.o_err_sum), 5);

        // start and abort together in DONE: abort wins
        bus.i_start = 1'b1;
        bus.i_abort = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        check_eq("sa_busy", longint'(bus.o_busy), 0);
        check_eq("sa_done", longint'(bus.o_done), 0);

        run_sweep(0, 2, 100);            // abort at RUN cycle 100
        run_sweep(0, 0, 0);              // restart gives full results
        run_sweep(4, 0, 0);              // truncating approximate multiplier
        run_sweep(1, 3, Latency - 1);    // async reset mid-DRAIN

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
